// File: rtl/sram_rd_arbiter.sv
// Arbitrates IFU and LSU read requests onto one SRAM read port, one outstanding read at a time.
// Define SRAM_ARB_RR_EN for round-robin arbitration; by default LSU has fixed priority over IFU.
module sram_rd_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ifu_req_valid_i,
  output logic          ifu_req_ready_o,
  input  logic [AW-1:0] ifu_req_addr_i,
  output logic          ifu_rsp_valid_o,
  input  logic          ifu_rsp_ready_i,
  output logic [DW-1:0] ifu_rsp_data_o,
  input  logic          lsu_req_valid_i,
  output logic          lsu_req_ready_o,
  input  logic [AW-1:0] lsu_req_addr_i,
  output logic          lsu_rsp_valid_o,
  input  logic          lsu_rsp_ready_i,
  output logic [DW-1:0] lsu_rsp_data_o,
  output logic          sram_ren_o,
  output logic [AW-1:0] sram_raddr_o,
  input  logic [DW-1:0] sram_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = LSU owns the outstanding read
  logic [DW-1:0] buf_q, buf_d;
  logic          any_req;
  logic          pick_lsu;
  logic          owner_rdy;

  assign any_req   = ifu_req_valid_i | lsu_req_valid_i;
  assign owner_rdy = owner_q ? lsu_rsp_ready_i : ifu_rsp_ready_i;

`ifdef SRAM_ARB_RR_EN
  logic ptr_q, ptr_d;   // 1 = LSU wins the next tie

  assign pick_lsu = (ifu_req_valid_i & lsu_req_valid_i) ? ptr_q : lsu_req_valid_i;
  // After every grant the tie-break points at the requester that did not win.
  assign ptr_d    = (state_q == S_IDLE && any_req) ? ~pick_lsu : ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign pick_lsu = lsu_req_valid_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    buf_d           = buf_q;
    ifu_req_ready_o = 1'b0;
    lsu_req_ready_o = 1'b0;
    ifu_rsp_valid_o = 1'b0;
    ifu_rsp_data_o  = '0;
    lsu_rsp_valid_o = 1'b0;
    lsu_rsp_data_o  = '0;
    sram_ren_o      = 1'b0;
    sram_raddr_o    = '0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          sram_ren_o      = 1'b1;
          sram_raddr_o    = pick_lsu ? lsu_req_addr_i : ifu_req_addr_i;
          ifu_req_ready_o = ~pick_lsu;
          lsu_req_ready_o = pick_lsu;
          owner_d         = pick_lsu;
          state_d         = S_WAIT;
        end
      end
      S_WAIT: begin
        buf_d   = sram_rdata_i;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (owner_q) begin
          lsu_rsp_valid_o = 1'b1;
          lsu_rsp_data_o  = buf_q;
        end else begin
          ifu_rsp_valid_o = 1'b1;
          ifu_rsp_data_o  = buf_q;
        end
        if (owner_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are combinational from request inputs, so force them quiet while reset is held.
    if (rst_i) begin
      ifu_req_ready_o = 1'b0;
      lsu_req_ready_o = 1'b0;
      ifu_rsp_valid_o = 1'b0;
      ifu_rsp_data_o  = '0;
      lsu_rsp_valid_o = 1'b0;
      lsu_rsp_data_o  = '0;
      sram_ren_o      = 1'b0;
      sram_raddr_o    = '0;
    end
  end

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Randomized and directed bench for sram_rd_arbiter against a transaction-level reference model.
// Build with SRAM_ARB_RR_EN defined to check the round-robin variant.
module tb_sram_rd_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ifu_req_valid_i, ifu_req_ready_o;
  logic [31:0] ifu_req_addr_i;
  logic        ifu_rsp_valid_o, ifu_rsp_ready_i;
  logic [31:0] ifu_rsp_data_o;
  logic        lsu_req_valid_i, lsu_req_ready_o;
  logic [31:0] lsu_req_addr_i;
  logic        lsu_rsp_valid_o, lsu_rsp_ready_i;
  logic [31:0] lsu_rsp_data_o;
  logic        sram_ren_o;
  logic [31:0] sram_raddr_o;
  logic [31:0] sram_rdata_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a read is either absent or in flight for m_age cycles since its grant.
  bit          m_busy      = 0;
  int          m_age       = 0;
  bit          m_owner_lsu = 0;
  logic [31:0] m_data      = '0;
`ifdef SRAM_ARB_RR_EN
  bit          m_ptr_lsu   = 0;
`endif

  sram_rd_arbiter #(.AW(32), .DW(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .ifu_req_valid_i (ifu_req_valid_i),
    .ifu_req_ready_o (ifu_req_ready_o),
    .ifu_req_addr_i  (ifu_req_addr_i),
    .ifu_rsp_valid_o (ifu_rsp_valid_o),
    .ifu_rsp_ready_i (ifu_rsp_ready_i),
    .ifu_rsp_data_o  (ifu_rsp_data_o),
    .lsu_req_valid_i (lsu_req_valid_i),
    .lsu_req_ready_o (lsu_req_ready_o),
    .lsu_req_addr_i  (lsu_req_addr_i),
    .lsu_rsp_valid_o (lsu_rsp_valid_o),
    .lsu_rsp_ready_i (lsu_rsp_ready_i),
    .lsu_rsp_data_o  (lsu_rsp_data_o),
    .sram_ren_o      (sram_ren_o),
    .sram_raddr_o    (sram_raddr_o),
    .sram_rdata_i    (sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    if (a == 32'h8000_0010) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive inputs just after posedge, check at negedge, advance the model.
  task automatic cyc(input bit iv, input logic [31:0] ia, input bit lv, input logic [31:0] la,
                     input bit ir, input bit lr, input bit rs);
    bit          e_ir, e_lr, e_ren, e_iv, e_lv, win_lsu;
    logic [31:0] e_addr, e_id, e_ld;
    rst_i           = rs;
    ifu_req_valid_i = iv;
    ifu_req_addr_i  = ia;
    lsu_req_valid_i = lv;
    lsu_req_addr_i  = la;
    ifu_rsp_ready_i = ir;
    lsu_rsp_ready_i = lr;
    sram_rdata_i    = (m_busy && m_age == 1) ? m_data : $urandom;
    e_ir = 0; e_lr = 0; e_ren = 0; e_iv = 0; e_lv = 0; win_lsu = 0;
    e_addr = '0; e_id = '0; e_ld = '0;
    if (!rs) begin
      if (!m_busy) begin
        if (iv || lv) begin
`ifdef SRAM_ARB_RR_EN
          win_lsu = (iv && lv) ? m_ptr_lsu : lv;
`else
          win_lsu = lv;
`endif
          e_ren  = 1;
          e_addr = win_lsu ? la : ia;
          e_ir   = !win_lsu;
          e_lr   = win_lsu;
        end
      end else if (m_age >= 2) begin
        if (m_owner_lsu) begin e_lv = 1; e_ld = m_data; end
        else begin e_iv = 1; e_id = m_data; end
      end
    end
    @(negedge clk_i);
    check("ifu_req_ready", ifu_req_ready_o, e_ir);
    check("lsu_req_ready", lsu_req_ready_o, e_lr);
    check("sram_ren", sram_ren_o, e_ren);
    check("sram_raddr", sram_raddr_o, e_addr);
    check("ifu_rsp_valid", ifu_rsp_valid_o, e_iv);
    check("ifu_rsp_data", ifu_rsp_data_o, e_id);
    check("lsu_rsp_valid", lsu_rsp_valid_o, e_lv);
    check("lsu_rsp_data", lsu_rsp_data_o, e_ld);
    if (rs) begin
      m_busy = 0;
`ifdef SRAM_ARB_RR_EN
      m_ptr_lsu = 0;
`endif
    end else if (!m_busy) begin
      if (e_ren) begin
        m_busy      = 1;
        m_age       = 1;
        m_owner_lsu = win_lsu;
        m_data      = mem(e_addr);
`ifdef SRAM_ARB_RR_EN
        m_ptr_lsu   = !win_lsu;
`endif
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_owner_lsu ? lr : ir) begin
      m_busy = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 32'h0, 0, 32'h0, 1, 1, 0);
  endtask

  initial begin
    bit          iv, lv, ir, lr, rs;
    logic [31:0] ia, la;
    rst_i = 1; ifu_req_valid_i = 0; lsu_req_valid_i = 0;
    ifu_req_addr_i = '0; lsu_req_addr_i = '0;
    ifu_rsp_ready_i = 0; lsu_rsp_ready_i = 0; sram_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    // Reset held with both requesters active: everything must stay quiet.
    for (int i = 0; i < 3; i++) cyc(1, 32'h8000_0000, 1, 32'h8000_0100, 1, 1, 1);

    // Single IFU fetch, first grant right after reset release.
    cyc(1, 32'h8000_0000, 0, 32'h0, 1, 1, 0);
    idle(4);

    // Both requesters held valid for several grants.
    for (int i = 0; i < 12; i++) cyc(1, 32'h8000_0000, 1, 32'h8000_0100, 1, 1, 0);
    idle(3);

    // LSU response back-pressured for five cycles while IFU keeps asking.
    cyc(0, 32'h0, 1, 32'h8000_0010, 1, 0, 0);
    cyc(1, 32'h8000_0000, 0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 32'h8000_0000, 0, 32'h0, 1, 0, 0);
    cyc(0, 32'h0, 0, 32'h0, 0, 1, 0);
    idle(2);

    // Reset while the LSU read is in flight, then a normal IFU fetch.
    cyc(0, 32'h0, 1, 32'h8000_0010, 1, 1, 0);
    cyc(0, 32'h0, 0, 32'h0, 1, 1, 1);
    idle(3);
    cyc(1, 32'h8000_0000, 0, 32'h0, 1, 1, 0);
    idle(3);

    // IFU pulses valid only while the LSU response is pending.
    cyc(0, 32'h0, 1, 32'h8000_0100, 0, 0, 0);
    cyc(0, 32'h0, 0, 32'h0, 0, 0, 0);
    cyc(1, 32'h8000_0000, 0, 32'h0, 0, 0, 0);
    cyc(0, 32'h0, 0, 32'h0, 0, 1, 0);
    idle(4);

    for (int i = 0; i < 4000; i++) begin
      iv = ($urandom % 3) != 0;
      lv = ($urandom % 3) == 0;
      ia = ($urandom % 4 == 0) ? 32'h8000_0000 : $urandom;
      la = ($urandom % 4 == 0) ? 32'h8000_0010 : $urandom;
      ir = ($urandom % 3) != 0;
      lr = ($urandom % 2) != 0;
      rs = ($urandom % 97) == 0;
      cyc(iv, ia, lv, la, ir, lr, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
